jk_flip_flop: RTL and testbench

Clocked JK flip-flop register. Updates on the rising edge of `clk` and has a synchronous, active-high reset. It is a general-purpose state element for counters, toggling control flags and divider logic. A `WIDTH` parameter makes it a bank of independent JK bits; the default is a single bit.

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_flip_flop_if.sv | 16 +
 rtl/jk_cell.sv | 27 ++
 rtl/jk_flip_flop.sv | 34 +++
 tb/tb_jk_flip_flop.sv | 134 +++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop types and next-state rule.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_mode_t;

  // Next state of one JK bit given its {j,k} mode and current value.
  function automatic logic jk_next(jk_mode_t mode, logic q);
    logic nxt;
    nxt = q;
    case (mode)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_flip_flop_if.sv
// JK register bank bus: per-bit set/clear requests in, state and its complement out.
interface jk_flip_flop_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;

  modport master (output j, output k, input q, input qn);
  modport slave  (input j, input k, output q, output qn);

endinterface

// File: rtl/jk_cell.sv
// Single-bit JK flop with synchronous active-high reset.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_mode_t mode;

  assign mode = jk_mode_t'({j, k});

  // Reset dominates j/k, even when they are unknown.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= jk_next(mode, q);
    end
  end

endmodule

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK flops; qn is the complement taken straight off the flops.
module jk_flip_flop
  import jk_pkg::*;
#(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_flip_flop_if.slave        bus
);

  logic [WIDTH-1:0] q_r;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    jk_cell #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .j   (bus.j[i]),
      .k   (bus.k[i]),
      .q   (q_r[i])
    );
  end

  assign bus.q  = q_r;
  assign bus.qn = ~q_r;

  // Simulation-only sanity properties.
  a_reset_value : assert property (@(posedge clk) $past(rst) |-> (q_r == RESET_VALUE));
  a_qn_compl    : assert property (@(posedge clk) !$isunknown(q_r) |-> (bus.qn == ~q_r));

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed-vector bench for jk_flip_flop: a 1-bit instance and a 4-bit instance with RESET_VALUE 4'b1010.
module tb_jk_flip_flop;

  logic clk;
  logic rst1;
  logic rst4;

  int n_checks;
  int n_errors;

  jk_flip_flop_if #(.WIDTH(1)) bus1 ();
  jk_flip_flop_if #(.WIDTH(4)) bus4 ();

  jk_flip_flop #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  jk_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // 1-bit instance: check q and qn together.
  task automatic chk1(input string tag, input logic exp);
    check({tag, ".q"},  {3'b000, bus1.q},  {3'b000, exp});
    check({tag, ".qn"}, {3'b000, bus1.qn}, {3'b000, ~exp});
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp);
    check({tag, ".q4"},  bus4.q,  exp);
    check({tag, ".qn4"}, bus4.qn, ~exp);
  endtask

  // Apply inputs at the falling edge, then sample 10 ns after the next rising edge.
  task automatic step1(input logic r, input logic jj, input logic kk);
    @(negedge clk);
    rst1   = r;
    bus1.j = jj;
    bus1.k = kk;
    @(posedge clk);
    #10;
  endtask

  task automatic step4(input logic r, input logic [3:0] jj, input logic [3:0] kk);
    @(negedge clk);
    rst4   = r;
    bus4.j = jj;
    bus4.k = kk;
    @(posedge clk);
    #10;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst1   = 1'b1;
    rst4   = 1'b1;
    bus1.j = 1'bx;
    bus1.k = 1'bx;
    bus4.j = 4'bxxxx;
    bus4.k = 4'bxxxx;

    // Reset with j/k unknown.
    @(posedge clk);
    #10;
    chk1("reset", 1'b0);
    chk4("reset", 4'b1010);

    step1(1'b0, 1'b0, 1'b0); chk1("hold",   1'b0);
    step1(1'b0, 1'b0, 1'b1); chk1("clear",  1'b0);
    step1(1'b0, 1'b1, 1'b0); chk1("set",    1'b1);
    step1(1'b0, 1'b1, 1'b1); chk1("tog0",   1'b0);
    step1(1'b0, 1'b1, 1'b1); chk1("tog1",   1'b1);
    step1(1'b0, 1'b1, 1'b1); chk1("tog2",   1'b0);
    step1(1'b1, 1'b1, 1'b1); chk1("rstpri", 1'b0);
    step1(1'b0, 1'b1, 1'b1); chk1("resume1", 1'b1);

    // Glitches between edges must not reach q.
    rst1   = 1'b1;
    bus1.j = 1'b0;
    bus1.k = 1'b1;
    #20;
    chk1("noasync", 1'b1);
    rst1   = 1'b0;
    bus1.j = 1'b1;
    bus1.k = 1'b1;
    @(posedge clk);
    #10;
    chk1("resume0", 1'b0);

    step1(1'b0, 1'b0, 1'b0); chk1("hold0", 1'b0);

    // Multi-bit: mixed per-bit modes from RESET_VALUE 1010.
    step4(1'b1, 4'bxxxx, 4'bxxxx);  chk4("m_reset", 4'b1010);
    step4(1'b0, 4'b0011, 4'b0101);  chk4("m_mix1",  4'b1011);
    step4(1'b0, 4'b0011, 4'b0101);  chk4("m_mix2",  4'b1010);
    step4(1'b0, 4'b0011, 4'b0101);  chk4("m_mix3",  4'b1011);
    step4(1'b0, 4'b0000, 4'b1111);  chk4("m_clr",   4'b0000);
    step4(1'b0, 4'b1111, 4'b0000);  chk4("m_set",   4'b1111);
    step4(1'b0, 4'b0000, 4'b0000);  chk4("m_hold",  4'b1111);
    step4(1'b0, 4'b1111, 4'b1111);  chk4("m_tog",   4'b0000);
    step4(1'b1, 4'b1111, 4'b1111);  chk4("m_rstpri", 4'b1010);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
